cpu_seq_ctrl: RTL and testbench
===============================

Name: cpu_seq_ctrl

Overview:
- Per-instruction control sequencer for the SimpleCPU datapath.
- Once the clock generator's fetch strobe has started the machine, it steps a fixed 8-cycle instruction frame (S0..S7).
- Each cycle it emits registered control strobes to the PC, instruction register, accumulator, memory and data-bus driver.
- Strobe values are decoded from the current opcode and the ALU zero flag.
- HLT stops the machine until reset.

Parameters:
- OP_HLT, 3'b000, halt opcode
- OP_SKZ, 3'b001, skip next instruction if zero
- OP_ADD, 3'b010, acc <= acc + mem
- OP_AND, 3'b011, acc <= acc & mem
- OP_XOR, 3'b100, acc <= acc ^ mem
- OP_LDA, 3'b101, acc <= mem
- OP_STO, 3'b110, mem <= acc
- OP_JMP, 3'b111, pc <= address

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clk
- fetch  in  1  start strobe from clk_gen; first sampled high launches the sequencer
- opcode  in  3  instruction-register opcode field; valid and stable from S3 onward
- zero  in  1  accumulator-zero flag from ALU
- inc_pc  out  1  increment program counter
- load_pc  out  1  load PC from instruction address field
- load_acc  out  1  load accumulator from ALU result
- load_ir  out  1  load instruction register (byte per cycle)
- rd  out  1  memory read enable
- wr  out  1  memory write enable
- datactl_ena  out  1  drive accumulator onto data bus
- halt  out  1  machine halted (sticky)

Behaviour:
- State register: IDLE, S0..S7, HALT (one-hot or encoded, designer's choice).
- All outputs are registered. On the edge where state==Sk, the outputs load row Sk and state advances, so row Sk is visible while state==S(k+1).
- Any strobe not listed in a row is 0 for that row.
- Reset: on any posedge with reset=1, state<=IDLE and all outputs <=0, including halt. Reset wins over every other condition and may arrive mid-frame.
- IDLE: all outputs 0. If fetch==1, go to S0; otherwise stay. After launch, fetch is ignored and the sequencer free-runs S7->S0.
- Row S0: rd=1, load_ir=1, inc_pc=1.
- Row S1: rd=1, load_ir=1.
- Row S2: all 0 (IR settles).
- Row S3:
  - opcode==OP_HLT: halt=1, state<=HALT instead of S4.
  - Otherwise: inc_pc=1.
- Row S4:
  - ADD/AND/XOR/LDA: rd=1.
  - STO: datactl_ena=1.
- Row S5:
  - ADD/AND/XOR/LDA: rd=1, load_acc=1.
  - STO: datactl_ena=1, wr=1.
  - JMP: load_pc=1.
  - SKZ with zero==1: inc_pc=1.
- Row S6:
  - ADD/AND/XOR/LDA: rd=1.
  - STO: datactl_ena=1.
  - SKZ with zero==1: inc_pc=1.
- Row S7: all 0; state<=S0.
- SKZ zero sampling:
  - zero is sampled live at the S5 edge and again at the S6 edge.
  - zero must be stable across S5..S6; if it changes between them, the result is 0, 1 or 2 inc_pc pulses and the bench does not check it.
  - Net effect of SKZ with zero==1: PC advances by 2 extra (skips a 2-byte instruction).
- HALT:
  - halt held 1, every other output 0, opcode/zero/fetch ignored.
  - Only reset leaves HALT.
- Invariants, for any opcode:
  - wr is never 1 unless datactl_ena is 1 in the same cycle.
  - rd and wr are never both 1.
  - load_pc and inc_pc are never both 1.
- Opcode changes between S3 and S6 are used as-is; keeping opcode stable is the instruction register's responsibility.
- One instruction takes exactly 8 clocks; no stalls, no handshake with memory.

Test Plan:
- Reset, hold fetch=0 for 5 clk -> state stays IDLE, all outputs 0. Pulse fetch=1 -> next 8 clk rows S0..S7 appear in order, beginning with rd=load_ir=inc_pc=1.
- opcode=OP_LDA over one frame -> rd high in rows S0, S1, S4, S5, S6; load_acc high only in row S5; inc_pc high in rows S0 and S3; wr, datactl_ena and load_pc never high.
- opcode=OP_STO -> datactl_ena high rows S4-S6; wr high only in row S5; rd high only in rows S0-S1.
- opcode=OP_SKZ with zero=1 -> inc_pc high in rows S0, S3, S5, S6 (4 pulses). Repeat with zero=0 -> inc_pc high in rows S0 and S3 only (2 pulses).
- opcode=OP_JMP -> load_pc high only in row S5, inc_pc low in rows S4-S7. opcode=OP_HLT -> halt rises after the S3 edge and stays 1 for 20+ clk with all other outputs 0 despite fetch toggling.
- Assert reset for 1 clk while state==S5 with opcode=OP_STO -> wr, datactl_ena and halt all 0 on the next edge, state IDLE. Repeat after HLT -> halt clears, relaunch on fetch works.

Source files
------------

// File: rtl/cpu_seq_ctrl.sv
// Per-instruction control sequencer: steps an 8-cycle frame S0..S7 and emits datapath strobes.
// Latency: strobes are registered, so the row decoded in state Sk is visible while in S(k+1).
// No backpressure: the frame free-runs after fetch launches it; only reset leaves HALT.
module cpu_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       fetch,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       inc_pc,
  output logic       load_pc,
  output logic       load_acc,
  output logic       load_ir,
  output logic       rd,
  output logic       wr,
  output logic       datactl_ena,
  output logic       halt
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_S0   = 4'd1;
  localparam logic [3:0] ST_S1   = 4'd2;
  localparam logic [3:0] ST_S2   = 4'd3;
  localparam logic [3:0] ST_S3   = 4'd4;
  localparam logic [3:0] ST_S4   = 4'd5;
  localparam logic [3:0] ST_S5   = 4'd6;
  localparam logic [3:0] ST_S6   = 4'd7;
  localparam logic [3:0] ST_S7   = 4'd8;
  localparam logic [3:0] ST_HALT = 4'd9;

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic       inc_pc_nxt, load_pc_nxt, load_acc_nxt, load_ir_nxt;
  logic       rd_nxt, wr_nxt, datactl_ena_nxt, halt_nxt;

  // Opcode classes; the four memory-operand ALU ops share one strobe pattern.
  logic is_alu, is_sto, is_jmp, is_skz;
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);
  assign is_sto = (opcode == OP_STO);
  assign is_jmp = (opcode == OP_JMP);
  assign is_skz = (opcode == OP_SKZ);

  // Decode next state and the strobe row for the current state.
  always_comb begin
    state_nxt       = state;
    inc_pc_nxt      = 1'b0;
    load_pc_nxt     = 1'b0;
    load_acc_nxt    = 1'b0;
    load_ir_nxt     = 1'b0;
    rd_nxt          = 1'b0;
    wr_nxt          = 1'b0;
    datactl_ena_nxt = 1'b0;
    halt_nxt        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch) state_nxt = ST_S0;
      end
      ST_S0: begin
        rd_nxt      = 1'b1;
        load_ir_nxt = 1'b1;
        inc_pc_nxt  = 1'b1;
        state_nxt   = ST_S1;
      end
      ST_S1: begin
        rd_nxt      = 1'b1;
        load_ir_nxt = 1'b1;
        state_nxt   = ST_S2;
      end
      ST_S2: begin
        state_nxt = ST_S3;
      end
      ST_S3: begin
        if (opcode == OP_HLT) begin
          halt_nxt  = 1'b1;
          state_nxt = ST_HALT;
        end else begin
          inc_pc_nxt = 1'b1;
          state_nxt  = ST_S4;
        end
      end
      ST_S4: begin
        rd_nxt          = is_alu;
        datactl_ena_nxt = is_sto;
        state_nxt       = ST_S5;
      end
      ST_S5: begin
        rd_nxt          = is_alu;
        load_acc_nxt    = is_alu;
        datactl_ena_nxt = is_sto;
        wr_nxt          = is_sto;
        load_pc_nxt     = is_jmp;
        inc_pc_nxt      = is_skz && zero;
        state_nxt       = ST_S6;
      end
      ST_S6: begin
        rd_nxt          = is_alu;
        datactl_ena_nxt = is_sto;
        inc_pc_nxt      = is_skz && zero;
        state_nxt       = ST_S7;
      end
      ST_S7: begin
        state_nxt = ST_S0;
      end
      ST_HALT: begin
        halt_nxt = 1'b1;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Register state and strobes; reset overrides everything, including a held halt.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      inc_pc      <= 1'b0;
      load_pc     <= 1'b0;
      load_acc    <= 1'b0;
      load_ir     <= 1'b0;
      rd          <= 1'b0;
      wr          <= 1'b0;
      datactl_ena <= 1'b0;
      halt        <= 1'b0;
    end else begin
      state       <= state_nxt;
      inc_pc      <= inc_pc_nxt;
      load_pc     <= load_pc_nxt;
      load_acc    <= load_acc_nxt;
      load_ir     <= load_ir_nxt;
      rd          <= rd_nxt;
      wr          <= wr_nxt;
      datactl_ena <= datactl_ena_nxt;
      halt        <= halt_nxt;
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed bench for cpu_seq_ctrl: per-row strobe vectors for each opcode class.
// Outputs are sampled 1 time unit after each rising edge.
// Frames run back to back; opcode is changed only at frame boundaries.
module tb_cpu_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       fetch;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  cpu_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .fetch       (fetch),
    .opcode      (opcode),
    .zero        (zero),
    .inc_pc      (inc_pc),
    .load_pc     (load_pc),
    .load_acc    (load_acc),
    .load_ir     (load_ir),
    .rd          (rd),
    .wr          (wr),
    .datactl_ena (datactl_ena),
    .halt        (halt)
  );

  // Row vector bit order: {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena}
  localparam logic [7:0] R0     = 8'b0100_1100;
  localparam logic [7:0] R1     = 8'b0000_1100;
  localparam logic [7:0] R2     = 8'b0000_0000;
  localparam logic [7:0] R3     = 8'b0100_0000;
  localparam logic [7:0] RH     = 8'b1000_0000;
  localparam logic [7:0] ALU_RD = 8'b0000_0100;
  localparam logic [7:0] ALU_LD = 8'b0001_0100;
  localparam logic [7:0] STO_EN = 8'b0000_0001;
  localparam logic [7:0] STO_WR = 8'b0000_0011;
  localparam logic [7:0] INC    = 8'b0100_0000;
  localparam logic [7:0] JMP_LD = 8'b0010_0000;
  localparam logic [7:0] NONE   = 8'b0000_0000;

  function automatic logic [63:0] frame(input logic [7:0] s4, input logic [7:0] s5,
                                        input logic [7:0] s6);
    return {NONE, s6, s5, s4, R3, R2, R1, R0};
  endfunction

  function automatic logic [7:0] outv();
    return {halt, inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, got[7:0], exp[7:0]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("inv wr_without_ena", {31'd0, wr & ~datactl_ena}, 32'd0);
    chk("inv rd_and_wr",      {31'd0, rd & wr},           32'd0);
    chk("inv ldpc_and_inc",   {31'd0, load_pc & inc_pc},  32'd0);
  endtask

  task automatic run_frame(input string name, input logic [63:0] f, input int nrows);
    for (int k = 0; k < nrows; k++) begin
      step();
      chk($sformatf("%s row S%0d", name, k), {24'd0, outv()}, {24'd0, f[k*8 +: 8]});
    end
  endtask

  initial begin
    reset  = 1'b1;
    fetch  = 1'b0;
    opcode = 3'b000;
    zero   = 1'b0;
    step();
    step();
    chk("reset outputs", {24'd0, outv()}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("idle cycle %0d", i), {24'd0, outv()}, 32'd0);
    end

    // Launch: the fetch edge itself emits the IDLE row.
    opcode = 3'b101;
    fetch  = 1'b1;
    step();
    chk("launch edge", {24'd0, outv()}, 32'd0);
    fetch = 1'b0;
    run_frame("LDA", frame(ALU_RD, ALU_LD, ALU_RD), 8);

    opcode = 3'b110;
    run_frame("STO", frame(STO_EN, STO_WR, STO_EN), 8);

    opcode = 3'b001; zero = 1'b1;
    run_frame("SKZ z1", frame(NONE, INC, INC), 8);
    zero = 1'b0;
    run_frame("SKZ z0", frame(NONE, NONE, NONE), 8);

    opcode = 3'b111; zero = 1'b1;
    run_frame("JMP", frame(NONE, JMP_LD, NONE), 8);

    // fetch held high mid-run must be ignored
    opcode = 3'b100; fetch = 1'b1;
    run_frame("XOR", frame(ALU_RD, ALU_LD, ALU_RD), 8);
    fetch = 1'b0;

    // Reset while state==S5 of a store
    opcode = 3'b110;
    run_frame("STO pre-reset", frame(STO_EN, STO_WR, STO_EN), 5);
    reset = 1'b1;
    step();
    chk("reset mid S5", {24'd0, outv()}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("idle after reset %0d", i), {24'd0, outv()}, 32'd0);
    end

    // HLT: halt rises after S3 and sticks regardless of inputs
    opcode = 3'b000;
    fetch  = 1'b1;
    step();
    chk("hlt launch edge", {24'd0, outv()}, 32'd0);
    fetch = 1'b0;
    run_frame("HLT", {32'd0, RH, R2, R1, R0}, 4);
    for (int i = 0; i < 22; i++) begin
      fetch  = i[0];
      opcode = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      step();
      chk($sformatf("halted cycle %0d", i), {24'd0, outv()}, {24'd0, RH});
    end

    // Reset clears halt; relaunch works
    fetch  = 1'b0;
    reset  = 1'b1;
    step();
    chk("reset clears halt", {24'd0, outv()}, 32'd0);
    reset  = 1'b0;
    opcode = 3'b101;
    fetch  = 1'b1;
    step();
    chk("relaunch edge", {24'd0, outv()}, 32'd0);
    fetch = 1'b0;
    run_frame("LDA relaunch", frame(ALU_RD, ALU_LD, ALU_RD), 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
